// File: rtl/spi_ram_ctrl_p_if.sv
// Word-level link between the SPI deserialiser/serialiser and spi_ram_ctrl_p.
// din carries {cmd[1:0], payload[DATA_W-1:0]}; dout/tx_valid/tx_ready form the read handshake.
interface spi_ram_ctrl_p_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;

  modport master (
    output din, rx_valid, tx_ready,
    input  dout, tx_valid
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output dout, tx_valid
  );
endinterface

// File: rtl/spi_ram_ctrl_p.sv
// Parametrised SPI command RAM with a registered, handshaked read path and sticky error flags.
// Optional address auto-increment for bursts is enabled by defining SPI_RAM_AUTOINC_EN.
module spi_ram_ctrl_p #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              sclk,
  input  logic              rst_n,
  spi_ram_ctrl_p_if.slave   bus,
  input  logic              clr_err,
  output logic              busy,
  output logic              err_addr,
  output logic              err_overrun
);

  localparam int unsigned       IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;
  typedef enum logic [1:0] {CMD_SET_WADDR, CMD_WRITE, CMD_SET_RADDR, CMD_READ} cmd_e;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              tx_valid_q, tx_valid_d;
  logic              err_addr_q, err_addr_d;
  logic              err_ovr_q, err_ovr_d;
  logic [DATA_W-1:0] dout_q;

  cmd_e              cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] payload;
  logic              addr_ok;
  logic              addr_bad_set;
  logic              ovr_set;
  logic              mem_we;

  assign cmd     = cmd_e'(bus.din[DATA_W+1:DATA_W]);
  assign addr    = bus.din[ADDR_W-1:0];
  assign payload = bus.din[DATA_W-1:0];
  // Extra bit lets MEM_DEPTH == 2**ADDR_W compare correctly.
  assign addr_ok = ({1'b0, addr} < DEPTH_L);

`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    tx_valid_d   = tx_valid_q;
    addr_bad_set = 1'b0;
    ovr_set      = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: ;
      FETCH: begin
        state_d    = HOLD;
        tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
        raddr_d    = addr_inc(raddr_q);
`endif
      end
      HOLD: begin
        if (bus.tx_ready) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // An explicit set-read-address in the FETCH cycle overrides the auto-increment.
    if (bus.rx_valid) begin
      case (cmd)
        CMD_SET_WADDR: begin
          if (addr_ok) waddr_d = addr;
          else         addr_bad_set = 1'b1;
        end
        CMD_WRITE: begin
          mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
          waddr_d = addr_inc(waddr_q);
`endif
        end
        CMD_SET_RADDR: begin
          if (addr_ok) raddr_d = addr;
          else         addr_bad_set = 1'b1;
        end
        CMD_READ: begin
          if (state_q == IDLE) state_d = FETCH;
          else                 ovr_set = 1'b1;
        end
        default: ;
      endcase
    end

    err_addr_d = (err_addr_q & ~clr_err) | addr_bad_set;
    err_ovr_d  = (err_ovr_q  & ~clr_err) | ovr_set;
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      waddr_q    <= '0;
      raddr_q    <= '0;
      tx_valid_q <= 1'b0;
      err_addr_q <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      tx_valid_q <= tx_valid_d;
      err_addr_q <= err_addr_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  // Storage has no reset; read and write share an edge, so a same-edge write returns old data.
  always_ff @(posedge sclk) begin
    if (rst_n && mem_we) mem[waddr_q[IDX_W-1:0]] <= payload;
  end

  always_ff @(posedge sclk) begin
    if (!rst_n)                 dout_q <= '0;
    else if (state_q == FETCH)  dout_q <= mem[raddr_q[IDX_W-1:0]];
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy         = (state_q != IDLE);
  assign err_addr     = err_addr_q;
  assign err_overrun  = err_ovr_q;

endmodule

// File: tb/tb_spi_ram_ctrl_p.sv
// Directed bench for spi_ram_ctrl_p (DATA_W=8, ADDR_W=8, MEM_DEPTH=200).
// Expectations for the burst section follow SPI_RAM_AUTOINC_EN.
module tb_spi_ram_ctrl_p;

  logic sclk;
  logic rst_n;
  logic clr_err;
  logic busy;
  logic err_addr;
  logic err_overrun;

  int unsigned n_checks;
  int unsigned n_fail;

  spi_ram_ctrl_p_if #(.DATA_W(8)) bus ();

  spi_ram_ctrl_p #(
    .DATA_W    (8),
    .ADDR_W    (8),
    .MEM_DEPTH (200)
  ) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clr_err     (clr_err),
    .busy        (busy),
    .err_addr    (err_addr),
    .err_overrun (err_overrun)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called and returns at a negedge; the command is sampled at the posedge in between.
  task automatic send(input logic [1:0] c, input logic [7:0] p);
    bus.din      = {c, p};
    bus.rx_valid = 1'b1;
    @(negedge sclk);
    bus.rx_valid = 1'b0;
    bus.din      = '0;
  endtask

  task automatic rd_cur(input logic [7:0] exp, input string tag);
    send(2'b11, 8'h00);
    check({tag, "_fetch_tv"},   bus.tx_valid, 1'b0);
    check({tag, "_fetch_busy"}, busy,         1'b1);
    @(negedge sclk);
    check({tag, "_tv"},   bus.tx_valid, 1'b1);
    check({tag, "_dout"}, bus.dout,     exp);
    bus.tx_ready = 1'b1;
    @(negedge sclk);
    bus.tx_ready = 1'b0;
    check({tag, "_done_tv"},   bus.tx_valid, 1'b0);
    check({tag, "_done_busy"}, busy,         1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    send(2'b10, a);
    rd_cur(exp, tag);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge sclk);
    clr_err = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    clr_err      = 1'b0;
    bus.din      = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (2) @(negedge sclk);
    check("rst_dout",    bus.dout,     8'h00);
    check("rst_tv",      bus.tx_valid, 1'b0);
    check("rst_busy",    busy,         1'b0);
    check("rst_err_a",   err_addr,     1'b0);
    check("rst_err_o",   err_overrun,  1'b0);
    rst_n = 1'b1;
    @(negedge sclk);

    // Basic write/read with tx_ready held low in HOLD.
    send(2'b00, 8'h05);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h05);
    send(2'b11, 8'h00);
    check("basic_e_tv",   bus.tx_valid, 1'b0);
    check("basic_e_busy", busy,         1'b1);
    @(negedge sclk);
    check("basic_e1_tv",   bus.tx_valid, 1'b1);
    check("basic_e1_dout", bus.dout,     8'hA5);
    repeat (3) @(negedge sclk);
    check("basic_hold_tv",   bus.tx_valid, 1'b1);
    check("basic_hold_dout", bus.dout,     8'hA5);
    check("basic_hold_busy", busy,         1'b1);

    // Overrun while in HOLD, clear, then clear coinciding with a new overrun.
    send(2'b11, 8'h00);
    check("ovr_flag", err_overrun,  1'b1);
    check("ovr_dout", bus.dout,     8'hA5);
    check("ovr_tv",   bus.tx_valid, 1'b1);
    pulse_clr();
    check("ovr_clr", err_overrun, 1'b0);
    clr_err = 1'b1;
    send(2'b11, 8'h00);
    clr_err = 1'b0;
    check("ovr_set_wins", err_overrun, 1'b1);
    pulse_clr();
    bus.tx_ready = 1'b1;
    @(negedge sclk);
    bus.tx_ready = 1'b0;
    check("basic_rel_tv",   bus.tx_valid, 1'b0);
    check("basic_rel_busy", busy,         1'b0);
    check("ovr_idle_none",  err_overrun,  1'b0);

    // Out-of-range address leaves write_addr; boundary MEM_DEPTH-1 is accepted.
    send(2'b00, 8'h20);
    send(2'b00, 8'hC8);
    check("bad_waddr_err", err_addr, 1'b1);
    send(2'b01, 8'h3C);
    rd(8'h20, 8'h3C, "bad_wr");
    pulse_clr();
    check("bad_clr", err_addr, 1'b0);
    send(2'b10, 8'h20);
    send(2'b10, 8'hC8);
    check("bad_raddr_err", err_addr, 1'b1);
    rd_cur(8'h3C, "bad_rd_keep");
    pulse_clr();
    send(2'b00, 8'hC7);
    send(2'b01, 8'h77);
    check("edge_addr_ok", err_addr, 1'b0);
    rd(8'hC7, 8'h77, "edge_rd");

    // Write to read_addr on the FETCH edge: old data returned, new data stored.
    send(2'b00, 8'h10);
    send(2'b01, 8'h11);
    send(2'b00, 8'h10);
    send(2'b10, 8'h10);
    send(2'b11, 8'h00);
    send(2'b01, 8'h22);
    check("coll_tv",   bus.tx_valid, 1'b1);
    check("coll_dout", bus.dout,     8'h11);
    bus.tx_ready = 1'b1;
    @(negedge sclk);
    bus.tx_ready = 1'b0;
    rd(8'h10, 8'h22, "coll_new");

    // Reset in HOLD clears outputs but keeps memory.
    send(2'b00, 8'h30);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h30);
    send(2'b11, 8'h00);
    @(negedge sclk);
    check("rsth_pre_dout", bus.dout, 8'hA5);
    rst_n = 1'b0;
    @(negedge sclk);
    rst_n = 1'b1;
    check("rsth_dout", bus.dout,     8'h00);
    check("rsth_tv",   bus.tx_valid, 1'b0);
    check("rsth_busy", busy,         1'b0);
    rd(8'h30, 8'hA5, "rsth_mem");

    // Reset in FETCH aborts without a tx_valid pulse; addresses return to 0.
    send(2'b10, 8'h30);
    send(2'b11, 8'h00);
    rst_n = 1'b0;
    @(negedge sclk);
    rst_n = 1'b1;
    check("rstf_tv0",  bus.tx_valid, 1'b0);
    check("rstf_busy", busy,         1'b0);
    @(negedge sclk);
    check("rstf_tv1",  bus.tx_valid, 1'b0);
    send(2'b01, 8'h5A);
    rd_cur(8'h5A, "rst_addr0");

    // Burst writes across the MEM_DEPTH-1 wrap.
    send(2'b00, 8'hC6);
    send(2'b01, 8'h01);
    send(2'b01, 8'h02);
    send(2'b01, 8'h03);
`ifdef SPI_RAM_AUTOINC_EN
    send(2'b10, 8'hC6);
    rd_cur(8'h01, "burst0");
    rd_cur(8'h02, "burst1");
    rd_cur(8'h03, "burst2");
    rd(8'h00, 8'h03, "burst_wrap");
`else
    rd(8'hC6, 8'h03, "noinc_c6");
    rd(8'hC7, 8'h77, "noinc_c7");
    rd(8'h00, 8'h5A, "noinc_00");
    rd_cur(8'h5A, "noinc_rd_fixed");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl_p.md
Name: spi_ram_ctrl_p

Overview:
Parametrised single-port synchronous RAM behind the SPI slave's 2-bit-command + payload word interface. It generalises the 8x256 store with configurable data, address and depth. It adds a registered read path held under a tx_valid/tx_ready handshake, sticky error flags, and optional address auto-increment for burst transfers. It sits between the SPI slave shift/deserialiser and the MISO serialiser, all in the sclk domain.

Parameters:
DATA_W, 8, memory word width and payload width
ADDR_W, 8, address register width; must satisfy ADDR_W <= DATA_W
MEM_DEPTH, 256, number of words; 2 <= MEM_DEPTH <= 2**ADDR_W, need not be a power of 2

Ports:
sclk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous reset, active-low
din  in  DATA_W+2  [DATA_W+1:DATA_W] = command, [DATA_W-1:0] = payload
rx_valid  in  1  din valid this cycle
tx_ready  in  1  serialiser has taken dout
dout  out  DATA_W  read data, registered
tx_valid  out  1  dout valid; held until tx_ready
busy  out  1  read in flight (state != IDLE)
err_addr  out  1  sticky: address payload >= MEM_DEPTH
err_overrun  out  1  sticky: read command received while busy
clr_err  in  1  clears both sticky flags

Behaviour:
- Reset: rst_n sampled low at posedge sets dout=0, tx_valid=0, write_addr=0, read_addr=0, err_addr=0, err_overrun=0, state=IDLE. Memory contents are not cleared and survive reset. Reset mid-read aborts the read with no tx_valid pulse.
- Commands are decoded only when rx_valid=1; otherwise din is ignored.
- Address payload is addr = din[ADDR_W-1:0]. Bits above ADDR_W are ignored.
- Command 00 (set write address): if addr < MEM_DEPTH, write_addr <= addr. Otherwise set err_addr and leave write_addr unchanged.
- Command 01 (write data): mem[write_addr] <= din[DATA_W-1:0]. This is accepted in any state, including while a read is pending.
- Command 10 (set read address): same rules as 00, applied to read_addr.
- Command 11 (read):
  - In IDLE: go to FETCH.
  - In FETCH or HOLD: set err_overrun and drop the command. State, dout and read_addr are unchanged.
- State machine, with command 11 accepted at edge E:
  - IDLE -> FETCH at edge E.
  - FETCH -> HOLD at edge E+1. At that edge: dout <= mem[read_addr], tx_valid <= 1.
  - HOLD: dout and tx_valid are held stable. At the first posedge with tx_ready=1: tx_valid <= 0 and state -> IDLE. A new 11 is accepted from the following edge.
  - Minimum spacing is 3 edges per read when tx_ready is held high.
- tx_ready is ignored in IDLE and FETCH.
- Read/write collision: a 01 write at edge E+1 to read_addr returns the OLD data (read-before-write).
- Wrap-around (auto-increment only): an address equal to MEM_DEPTH-1 increments to 0. This holds for non-power-of-2 depths.
- Error flags:
  - clr_err=1 clears both flags.
  - A set event in the same cycle as clr_err wins, so the flag stays 1.
  - Flags never clear otherwise (except on reset).
- busy is combinational from state.

Optional Feature:
Macro SPI_RAM_AUTOINC_EN.
- Defined: after each 01, write_addr <= write_addr+1 with wrap. At the FETCH edge, read_addr <= read_addr+1 with wrap. This supports bursts: one 00 followed by N 01s, and one 10 followed by N 11s.
- Undefined: addresses change only via 00/10. The auto-increment logic is absent.

Test Plan:
- Reset/basic: reset, then 00/0x05, 01/0xA5, 10/0x05, 11 with tx_ready=0 for 4 cycles -> tx_valid rises 2 edges after the 11, dout=0xA5 and stable; tx_ready=1 -> tx_valid=0 next edge, busy=0.
- Overrun: issue 11 while in HOLD -> err_overrun=1, dout unchanged. Pulse clr_err -> 0. Assert clr_err together with a new overrun -> flag stays 1.
- Bad address with MEM_DEPTH=200: 00/0xC8 -> err_addr=1, write_addr unchanged. Then 01/0x3C lands at the previous address.
- Collision: 00/0x10, 01/0x11 (mem[0x10]=0x11), 10/0x10, 11, then at the FETCH edge 01/0x22 -> dout=0x11. A later read of 0x10 returns 0x22.
- Auto-increment with the macro, MEM_DEPTH=256: 00/0xFE, 01 x3 with 1,2,3 -> mem[FE]=1, mem[FF]=2, mem[00]=3. Burst read from 0xFE returns 1,2,3. Without the macro, the same writes leave mem[FE]=3.
- Reset during HOLD with dout=0xA5 -> dout=0, tx_valid=0, state IDLE. A re-read of the address returns 0xA5 (memory retained).
